tv_player: RTL

Synthesizable test-vector engine for the MIPS datapath blocks. It works as the driving and checking end of our vector format: a host or boot loader writes packed `{stimulus, expected}` words into an internal vector memory. On `start`, the block plays each stimulus to the device under test, waits a settle interval, and compares the DUT response against the expected field. It reports tests run, errors and the first failing index, so flop and register blocks can be checked on hardware as well as in simulation.

---
 rtl/tv_player.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/tv_player.sv
// tv_player: test-vector engine. A host loads packed {stim, expected} words
// into the vector memory. On start, each stimulus is driven to the device
// under test, the response is sampled SETTLE cycles later, and it is checked
// against the expected field.
// Optional feature macro: TV_STOP_ON_ERROR_EN. When it is defined, the first
// mismatch ends the run. The default build plays every requested vector.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no run since reset; waiting for start
// S_APPLY | drive stim from mem[vec_idx] and load the settle counter
// S_WAIT  | settle; compare resp and advance on the last wait cycle
// S_DONE  | run finished; results and stim held until the next start
module tv_player #(
  parameter  int STIM_W = 4,
  parameter  int RESP_W = 1,
  parameter  int DEPTH  = 16,
  parameter  int SETTLE = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [AW-1:0]            wr_addr,
  input  logic [STIM_W+RESP_W-1:0] wr_data,
  input  logic [AW:0]              num_vec,
  input  logic                     start,
  output logic [STIM_W-1:0]        stim,
  input  logic [RESP_W-1:0]        resp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [AW-1:0]            vec_idx,
  output logic [AW:0]              tests_count,
  output logic [15:0]              err_count,
  output logic [AW-1:0]            fail_idx
);

  localparam int          VW      = STIM_W + RESP_W;
  localparam int          CW      = $clog2(SETTLE + 1);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

`ifdef TV_STOP_ON_ERROR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STIM_W-1:0]   stim_q, stim_d;
  logic [AW-1:0]       vec_idx_q, vec_idx_d;
  logic [AW:0]         tests_q, tests_d;
  logic [15:0]         err_q, err_d;
  logic [AW-1:0]       fail_idx_q, fail_idx_d;
  logic [AW:0]         num_q, num_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [VW-1:0]       mem_q [DEPTH];
  logic [VW-1:0]       mem_rd;
  logic [AW:0]         num_clamp;
  logic                mismatch;

  assign mem_rd    = mem_q[vec_idx_q];
  assign num_clamp = (num_vec > DEPTH_W) ? DEPTH_W : num_vec;

  // Vector memory: no reset so contents survive it; host writes are locked out during a run.
  always_ff @(posedge clk) begin
    if (wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W)) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      stim_q     <= '0;
      vec_idx_q  <= '0;
      tests_q    <= '0;
      err_q      <= '0;
      fail_idx_q <= '0;
      num_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      vec_idx_q  <= vec_idx_d;
      tests_q    <= tests_d;
      err_q      <= err_d;
      fail_idx_q <= fail_idx_d;
      num_q      <= num_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state and datapath update; start is only accepted from IDLE or DONE.
  always_comb begin
    state_d    = state_q;
    stim_d     = stim_q;
    vec_idx_d  = vec_idx_q;
    tests_d    = tests_q;
    err_d      = err_q;
    fail_idx_d = fail_idx_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    mismatch   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          num_d      = num_clamp;
          tests_d    = '0;
          err_d      = '0;
          fail_idx_d = '0;
          vec_idx_d  = '0;
          state_d    = (num_clamp == '0) ? S_DONE : S_APPLY;
        end
      end

      S_APPLY: begin
        stim_d  = mem_rd[VW-1:RESP_W];
        cnt_d   = CW'(SETTLE);
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (cnt_q == CW'(1)) begin
          // Case inequality so an X/Z response is reported as a failure.
          mismatch = (resp !== mem_rd[RESP_W-1:0]);
          tests_d  = tests_q + (AW+1)'(1);
          if (mismatch) begin
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 16'd1;
            end
            if (err_q == 16'd0) begin
              fail_idx_d = vec_idx_q;
            end
          end
          if ((tests_d == num_q) || (STOP_ON_ERR && mismatch)) begin
            state_d = S_DONE;
          end else begin
            vec_idx_d = vec_idx_q + AW'(1);
            state_d   = S_APPLY;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q == S_APPLY) || (state_q == S_WAIT);
    done = (state_q == S_DONE);
    pass = (state_q == S_DONE) && (err_q == 16'd0);
  end

  assign stim        = stim_q;
  assign vec_idx     = vec_idx_q;
  assign tests_count = tests_q;
  assign err_count   = err_q;
  assign fail_idx    = fail_idx_q;

endmodule
